// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execution unit. Logic, arithmetic and compare ops finish
// in one cycle. Shifts move one bit per cycle behind a start/busy/done handshake.
// Result and Zero are registered and change only at a completion or at reset.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLLV = 4'b0011;
  localparam logic [3:0] OP_SRLV = 4'b0100;
  localparam logic [3:0] OP_SRAV = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  // Shift direction/fill kinds held for the duration of a shift
  localparam logic [1:0] K_LEFT = 2'd0;
  localparam logic [1:0] K_SRL  = 2'd1;
  localparam logic [1:0] K_SRA  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [1:0]       r_kind;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;

  logic [4:0]       w_amt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_shift_nxt;

  function automatic logic f_is_shift(input logic [3:0] c);
    return (c == OP_SLL) || (c == OP_SRL) || (c == OP_SRA) ||
           (c == OP_SLLV) || (c == OP_SRLV) || (c == OP_SRAV);
  endfunction

  // Immediate shifts use shamt, variable shifts use the low five bits of A
  function automatic logic [4:0] f_amount(input logic [3:0] c, input logic [4:0] a5,
                                          input logic [4:0] sh);
    if ((c == OP_SLLV) || (c == OP_SRLV) || (c == OP_SRAV)) return a5;
    return sh;
  endfunction

  function automatic logic [1:0] f_kind(input logic [3:0] c);
    case (c)
      OP_SRL, OP_SRLV: return K_SRL;
      OP_SRA, OP_SRAV: return K_SRA;
      default:         return K_LEFT;
    endcase
  endfunction

  // Single-cycle result; shift codes only reach here with amount 0 and pass B
  function automatic logic [WIDTH-1:0] f_alu(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (c)
      OP_AND:           return a & b;
      OP_OR:            return a | b;
      OP_ADD:           return a + b;
      OP_SUB, OP_BNE:   return a - b;
      OP_SLT:           return {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU:          return {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:           return a ^ b;
      OP_NOR:           return ~(a | b);
      OP_SLL, OP_SRL, OP_SRA,
      OP_SLLV, OP_SRLV, OP_SRAV: return b;
      default:          return '0;
    endcase
  endfunction

  // BNE reports "operands differ" so branch resolution can use Zero directly
  function automatic logic f_zero(input logic [3:0] c, input logic [WIDTH-1:0] r);
    return (c == OP_BNE) ? (|r) : ~(|r);
  endfunction

  // Arithmetic right shift keeps the MSB, which is always the sign of the latched B
  function automatic logic [WIDTH-1:0] f_shift1(input logic [1:0] k, input logic [WIDTH-1:0] v);
    case (k)
      K_SRL:   return {1'b0, v[WIDTH-1:1]};
      K_SRA:   return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {v[WIDTH-2:0], 1'b0};
    endcase
  endfunction

  assign w_amt       = f_amount(ALUCtrl, A[4:0], shamt);
  assign w_alu       = f_alu(ALUCtrl, A, B);
  assign w_shift_nxt = f_shift1(r_kind, r_shreg);

  // Control FSM plus the architecturally visible Result/Zero/done registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (f_is_shift(ALUCtrl) && (w_amt != 5'd0)) begin
              r_cnt   <= w_amt;
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_alu;
              r_zero   <= f_zero(ALUCtrl, w_alu);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_shift_nxt;
            r_zero   <= ~(|w_shift_nxt);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shift datapath: loaded with B at acceptance, then one bit per SHIFT cycle
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && start) begin
      r_shreg <= B;
      r_kind  <= f_kind(ALUCtrl);
    end else if (r_state == S_SHIFT) begin
      r_shreg <= w_shift_nxt;
    end
  end

  assign Result = r_result;
  assign Zero   = r_zero;
  assign done   = r_done;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors for alu_exec_unit, checked every cycle
// against a behavioural model and pinned by hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [31:0] Result;
  logic        Zero;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUCtrl(ALUCtrl),
    .A(A), .B(B), .shamt(shamt),
    .Result(Result), .Zero(Zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] m_calc(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1000: return a - b;
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      4'b1011: return a ^ b;
      4'b1100: return ~(a | b);
      4'b1001: return b << sh;
      4'b1010: return b >> sh;
      4'b1101: return sb >>> sh;
      4'b0011: return b << a[4:0];
      4'b0100: return b >> a[4:0];
      4'b0101: return sb >>> a[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int m_amt(input logic [3:0] c, input logic [31:0] a, input logic [4:0] sh);
    case (c)
      4'b1001, 4'b1010, 4'b1101: return int'(sh);
      4'b0011, 4'b0100, 4'b0101: return int'(a[4:0]);
      default:                   return 0;
    endcase
  endfunction

  int          m_left = 0;   // cycles of busy still to be shown
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] pend_res;
  logic        pend_zero;

  always @(posedge clk) begin
    int k;
    m_done = 1'b0;
    if (reset) begin
      m_left = 0;
      m_res  = '0;
      m_zero = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        pend_res  = m_calc(ALUCtrl, A, B, shamt);
        pend_zero = (ALUCtrl == 4'b1000) ? (pend_res != 0) : (pend_res == 0);
        k = m_amt(ALUCtrl, A, shamt);
        m_left = k + 1;
        if (k == 0) begin
          m_res  = pend_res;
          m_zero = pend_zero;
          m_done = 1'b1;
        end
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_res  = pend_res;
        m_zero = pend_zero;
        m_done = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",   {31'd0, busy}, {31'd0, (m_left != 0)});
      chk("cyc_done",   {31'd0, done}, {31'd0, m_done});
      chk("cyc_Result", Result, m_res);
      chk("cyc_Zero",   {31'd0, Zero}, {31'd0, m_zero});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] er, input logic ez, input int el);
    int lat;
    ALUCtrl = c; A = a; B = b; shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ALUCtrl = ~c; A = ~a; B = ~b; shamt = ~sh;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_Result"}, Result, er);
    chk({nm, "_Zero"}, {31'd0, Zero}, {31'd0, ez});
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int ndone;
    reset = 1'b1; start = 1'b0; ALUCtrl = 4'd0; A = '0; B = '0; shamt = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_Result", Result, 32'h0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    run_op("ADD",   4'b0010, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 0);
    run_op("SUB",   4'b0110, 32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 1'b0, 0);
    run_op("SLT",   4'b0111, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 0);
    run_op("SLTU",  4'b1111, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 0);
    run_op("BNEeq", 4'b1000, 32'd3,        32'd3,        5'd0,  32'h0,        1'b0, 0);
    run_op("BNEne", 4'b1000, 32'd3,        32'd4,        5'd0,  32'hFFFFFFFF, 1'b1, 0);
    run_op("AND",   4'b0000, 32'hF0F0,     32'hFF00,     5'd0,  32'hF000,     1'b0, 0);
    run_op("OR",    4'b0001, 32'hF0F0,     32'hFF00,     5'd0,  32'hFFF0,     1'b0, 0);
    run_op("XOR",   4'b1011, 32'hF0F0,     32'hFF00,     5'd0,  32'h0FF0,     1'b0, 0);
    run_op("NOR",   4'b1100, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 0);
    run_op("SRA31", 4'b1101, 32'h0,        32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 31);
    run_op("SRLV4", 4'b0100, 32'h24,       32'h80000000, 5'd0,  32'h08000000, 1'b0, 4);
    run_op("SLL0",  4'b1001, 32'h0,        32'h1234,     5'd0,  32'h1234,     1'b0, 0);
    run_op("SLLV3", 4'b0011, 32'h3,        32'h1,        5'd0,  32'h8,        1'b0, 3);
    run_op("SRAV4", 4'b0101, 32'h4,        32'h70000000, 5'd0,  32'h07000000, 1'b0, 4);
    run_op("SRL1",  4'b1010, 32'h0,        32'h80000000, 5'd1,  32'h40000000, 1'b0, 1);
    run_op("SLL32", 4'b1001, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 31);

    // start pulsed mid-shift must be ignored
    ALUCtrl = 4'b1010; A = 32'h0; B = 32'hF0000000; shamt = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    ALUCtrl = 4'b0010; A = 32'd1; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ignstart_latency", lat, 8);
    chk("ignstart_Result", Result, 32'h00F00000);
    @(negedge clk);

    // reset after three shift edges aborts without done; reset beats start
    ALUCtrl = 4'b1001; A = 32'h0; B = 32'h1; shamt = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; start = 1'b1; ALUCtrl = 4'b0010; A = 32'd9; B = 32'd9;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("abort_Result", Result, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    run_op("UNDEF", 4'b1110, 32'h5,        32'h6,        5'd0,  32'h0,        1'b1, 0);
    run_op("ADDb2b",4'b0010, 32'h7,        32'h8,        5'd0,  32'hF,        1'b0, 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
